turbo_enc: RTL and testbench

- Rate-1/3 turbo encoder with 24 information bits per frame. It is the transmit-side counterpart of the Deco turbo decoder.
- Each frame produces an 84-bit terminated codeword (3*24 + 12 tail bits).
- The codeword leaves as four 21-bit words, in the same order and width that Deco consumes on data_i.
- Placement: upstream of Deco in loopback and golden-data generation, driving Deco's start_i/data_i.

---
 rtl/turbo_enc_if.sv | 24 ++
 rtl/turbo_enc.sv | 187 ++++++++++++++++++
 tb/tb_turbo_enc.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/turbo_enc_if.sv
// Codeword stream bundle between turbo_enc and its driver/consumer.
// master: the encoder side; slave: the side issuing frames and accepting words.
interface turbo_enc_if #(
    parameter int unsigned K = 24,
    parameter int unsigned W = 21
);
    logic         start_i;
    logic [K-1:0] data_i;
    logic         ready_i;
    logic         busy_o;
    logic         valid_o;
    logic [W-1:0] data_o;
    logic         done_o;

    modport master (
        input  start_i, data_i, ready_i,
        output busy_o, valid_o, data_o, done_o
    );

    modport slave (
        output start_i, data_i, ready_i,
        input  busy_o, valid_o, data_o, done_o
    );
endinterface

// File: rtl/turbo_enc.sv
// Rate-1/3 terminated turbo encoder, K=24, emitting an 84-bit codeword as four 21-bit words.
// Optional macro TURBO_ENC_FRAME_CNT_EN adds an 8-bit count of completed frames.
module turbo_enc (
    input  logic        clk_p_i,
    input  logic        reset_n_i,
`ifdef TURBO_ENC_FRAME_CNT_EN
    output logic [7:0]  frame_cnt_o,
`endif
    turbo_enc_if.master bus
);
    localparam int unsigned K  = 24;
    localparam int unsigned W  = 21;
    localparam int unsigned CW = 84;

    typedef enum logic [1:0] {StIdle, StEnc, StTail, StSend} state_e;

    state_e          r_state;
    logic [K-1:0]    r_info;
    logic [2:0]      r_s1;
    logic [2:0]      r_s2;
    logic [4:0]      r_bit_cnt;
    logic [1:0]      r_word_cnt;
    logic [CW-1:0]   r_cw;
    logic            r_busy;
    logic            r_valid;
    logic            r_done;
    logic [W-1:0]    r_data;
`ifdef TURBO_ENC_FRAME_CNT_EN
    logic [7:0]      r_frame_cnt;
`endif

    logic            w_x1;
    logic            w_x2;
    logic [3:0]      w_rsc1;
    logic [3:0]      w_rsc2;
    logic [CW-1:0]   w_cw_next;
    logic [1:0]      w_next_cnt;
    logic [W-1:0]    w_next_word;

    // Interleaver pi(i) = (5i + 6i^2) mod 24.
    function automatic logic [4:0] f_pi(input logic [4:0] i);
        unique case (i)
            5'd0:  f_pi = 5'd0;   5'd1:  f_pi = 5'd11;  5'd2:  f_pi = 5'd10;
            5'd3:  f_pi = 5'd21;  5'd4:  f_pi = 5'd20;  5'd5:  f_pi = 5'd7;
            5'd6:  f_pi = 5'd6;   5'd7:  f_pi = 5'd17;  5'd8:  f_pi = 5'd16;
            5'd9:  f_pi = 5'd3;   5'd10: f_pi = 5'd2;   5'd11: f_pi = 5'd13;
            5'd12: f_pi = 5'd12;  5'd13: f_pi = 5'd23;  5'd14: f_pi = 5'd22;
            5'd15: f_pi = 5'd9;   5'd16: f_pi = 5'd8;   5'd17: f_pi = 5'd19;
            5'd18: f_pi = 5'd18;  5'd19: f_pi = 5'd5;   5'd20: f_pi = 5'd4;
            5'd21: f_pi = 5'd15;  5'd22: f_pi = 5'd14;  5'd23: f_pi = 5'd1;
            default: f_pi = 5'd0;
        endcase
    endfunction

    // State s = {s3, s2, s1}; returns {z, next state}.
    function automatic logic [3:0] f_rsc(input logic x, input logic [2:0] s);
        logic a;
        a = x ^ s[1] ^ s[2];
        return {a ^ s[0] ^ s[2], s[1], s[0], a};
    endfunction

    always_comb begin
        // Tail input s2^s3 cancels the feedback so the register flushes to zero.
        w_x1   = (r_state == StTail) ? (r_s1[1] ^ r_s1[2]) : r_info[r_bit_cnt];
        w_x2   = (r_state == StTail) ? (r_s2[1] ^ r_s2[2]) : r_info[f_pi(r_bit_cnt)];
        w_rsc1 = f_rsc(w_x1, r_s1);
        w_rsc2 = f_rsc(w_x2, r_s2);

        w_cw_next = r_cw;
        if (r_state == StEnc) begin
            for (int i = 0; i < int'(K); i++) begin
                if (r_bit_cnt == 5'(i)) begin
                    w_cw_next[3*i]   = r_info[i];
                    w_cw_next[3*i+1] = w_rsc1[3];
                    w_cw_next[3*i+2] = w_rsc2[3];
                end
            end
        end else if (r_state == StTail) begin
            for (int j = 0; j < 3; j++) begin
                if (r_bit_cnt == 5'(j)) begin
                    w_cw_next[72+2*j] = w_x1;
                    w_cw_next[73+2*j] = w_rsc1[3];
                    w_cw_next[78+2*j] = w_x2;
                    w_cw_next[79+2*j] = w_rsc2[3];
                end
            end
        end

        w_next_cnt = r_word_cnt + 2'd1;
        case (w_next_cnt)
            2'd0:    w_next_word = r_cw[20:0];
            2'd1:    w_next_word = r_cw[41:21];
            2'd2:    w_next_word = r_cw[62:42];
            default: w_next_word = r_cw[83:63];
        endcase
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= StIdle;
            r_info     <= '0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_cw       <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_data     <= '0;
`ifdef TURBO_ENC_FRAME_CNT_EN
            r_frame_cnt <= '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.start_i) begin
                        r_info    <= bus.data_i;
                        r_s1      <= '0;
                        r_s2      <= '0;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= StEnc;
                    end
                end
                StEnc: begin
                    r_s1 <= w_rsc1[2:0];
                    r_s2 <= w_rsc2[2:0];
                    r_cw <= w_cw_next;
                    if (r_bit_cnt == 5'(K - 1)) begin
                        r_bit_cnt <= '0;
                        r_state   <= StTail;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                StTail: begin
                    r_s1 <= w_rsc1[2:0];
                    r_s2 <= w_rsc2[2:0];
                    r_cw <= w_cw_next;
                    if (r_bit_cnt == 5'd2) begin
                        // Word 0 holds only info-section bits, already final here.
                        r_bit_cnt  <= '0;
                        r_word_cnt <= '0;
                        r_valid    <= 1'b1;
                        r_done     <= 1'b0;
                        r_data     <= r_cw[20:0];
                        r_state    <= StSend;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                StSend: begin
                    if (bus.ready_i) begin
                        if (r_word_cnt == 2'd3) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_data  <= '0;
                            r_state <= StIdle;
`ifdef TURBO_ENC_FRAME_CNT_EN
                            r_frame_cnt <= r_frame_cnt + 8'd1;
`endif
                        end else begin
                            r_word_cnt <= w_next_cnt;
                            r_data     <= w_next_word;
                            r_done     <= (w_next_cnt == 2'd3);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy_o  = r_busy;
    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_data;
    assign bus.done_o  = r_done;
`ifdef TURBO_ENC_FRAME_CNT_EN
    assign frame_cnt_o = r_frame_cnt;
`endif

    a_term_zero: assert property (@(posedge clk_p_i) disable iff (!reset_n_i)
        (r_state == StSend) |-> (r_s1 == 3'b000 && r_s2 == 3'b000));

endmodule

// File: tb/tb_turbo_enc.sv
// Self-checking bench for turbo_enc: codeword model, per-cycle output compare, directed frames.
module tb_turbo_enc;
    logic clk_p_i   = 1'b0;
    logic reset_n_i = 1'b0;

    turbo_enc_if bus ();
`ifdef TURBO_ENC_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    turbo_enc dut (
        .clk_p_i     (clk_p_i),
        .reset_n_i   (reset_n_i),
`ifdef TURBO_ENC_FRAME_CNT_EN
        .frame_cnt_o (frame_cnt),
`endif
        .bus         (bus)
    );

    always #5 clk_p_i = ~clk_p_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          widx     = 0;
    int          cyc      = 0;
    int          frames_done = 0;
    int          words_accepted = 0;
    int          fc_model = 0;
    logic [83:0] exp_q[$];

    always @(posedge clk_p_i) cyc++;

    task automatic check(input string name, input logic [83:0] act, input logic [83:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Encoder model straight from the code rules: two RSC registers, formula interleaver.
    function automatic logic [83:0] golden(input logic [23:0] u);
        logic [83:0] cw;
        int st[2][3];
        int x, a, z;
        cw = '0;
        for (int e = 0; e < 2; e++) for (int b = 0; b < 3; b++) st[e][b] = 0;
        for (int i = 0; i < 24; i++) begin
            cw[3*i] = u[i];
            for (int e = 0; e < 2; e++) begin
                x = (e == 0) ? int'(u[i]) : int'(u[(5*i + 6*i*i) % 24]);
                a = x ^ st[e][1] ^ st[e][2];
                z = a ^ st[e][0] ^ st[e][2];
                st[e][2] = st[e][1]; st[e][1] = st[e][0]; st[e][0] = a;
                cw[3*i+1+e] = z[0];
            end
        end
        for (int j = 0; j < 3; j++) begin
            for (int e = 0; e < 2; e++) begin
                x = st[e][1] ^ st[e][2];
                a = x ^ st[e][1] ^ st[e][2];
                z = a ^ st[e][0] ^ st[e][2];
                st[e][2] = st[e][1]; st[e][1] = st[e][0]; st[e][0] = a;
                cw[72+6*e+2*j] = x[0];
                cw[73+6*e+2*j] = z[0];
            end
        end
        return cw;
    endfunction

    function automatic logic [20:0] word_of(input logic [83:0] cw, input int k);
        case (k)
            0:       return cw[20:0];
            1:       return cw[41:21];
            2:       return cw[62:42];
            default: return cw[83:63];
        endcase
    endfunction

    // Per-cycle compare against the head of the expected-frame queue.
    always @(negedge clk_p_i) begin
        if (!reset_n_i) begin
            exp_q.delete();
            widx = 0;
            fc_model = 0;
        end else if (bus.valid_o) begin
            if (exp_q.size() == 0) begin
                check("valid_without_frame", 84'(bus.valid_o), 84'(0));
            end else begin
                check("data_word", 84'(bus.data_o), 84'(word_of(exp_q[0], widx)));
                check("done_flag", 84'(bus.done_o), 84'(widx == 3));
                check("busy_in_send", 84'(bus.busy_o), 84'(1));
                if (bus.ready_i) begin
                    words_accepted++;
                    widx++;
                    if (widx == 4) begin
                        widx = 0;
                        void'(exp_q.pop_front());
                        frames_done++;
                        fc_model = (fc_model + 1) % 256;
                    end
                end
            end
        end else begin
            check("done_without_valid", 84'(bus.done_o), 84'(0));
        end
    end

    task automatic tick();
        @(posedge clk_p_i);
        #1;
    endtask

    task automatic send(input logic [23:0] u, output int acc_cyc);
        int b = 0;
        while (bus.busy_o && b < 100) begin tick(); b++; end
        if (bus.busy_o) check("idle_timeout", 84'(bus.busy_o), 84'(0));
        bus.data_i  = u;
        bus.start_i = 1'b1;
        exp_q.push_back(golden(u));
        tick();
        acc_cyc = cyc;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.valid_o && n < 60) begin tick(); n++; end
        if (!bus.valid_o) check("valid_timeout", 84'(bus.valid_o), 84'(1));
    endtask

    task automatic wait_frames(input int target);
        int b = 0;
        while (frames_done < target && b < 300) begin tick(); b++; end
        check("frames_completed", 84'(frames_done), 84'(target));
    endtask

    logic [83:0] g;
    int          n, t, t_prev, acc0;
    logic [23:0] vecs [4] = '{24'hA5C396, 24'h800000, 24'h5A5A5A, 24'h123456};

    initial begin
        bus.start_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b1;
        repeat (3) tick();
        check("rst_busy", 84'(bus.busy_o), 84'(0));
        check("rst_valid", 84'(bus.valid_o), 84'(0));
        check("rst_done", 84'(bus.done_o), 84'(0));
        check("rst_data", 84'(bus.data_o), 84'(0));
        reset_n_i = 1'b1;
        tick();

        // Hand-computed pins on the model.
        g = golden(24'h0);
        check("model_zero", g, 84'(0));
        g = golden(24'h000001);
        check("model_impulse_w0", 84'(g[5:0]), 84'(6'b110111));

        // All-zero frame: latency, and busy drops right after the last word.
        send(24'h0, t);
        wait_valid(n);
        check("first_valid_edge", 84'(n + 1), 84'(28));
        repeat (3) tick();
        check("busy_before_last", 84'(bus.busy_o), 84'(1));
        check("valid_before_last", 84'(bus.valid_o), 84'(1));
        tick();
        check("busy_after_last", 84'(bus.busy_o), 84'(0));
        check("valid_after_last", 84'(bus.valid_o), 84'(0));
        wait_frames(1);

        // Impulse: literal low bits, encoders terminated.
        send(24'h000001, t);
        wait_valid(n);
        check("impulse_w0_low", 84'(bus.data_o[5:0]), 84'(6'b110111));
        check("enc1_terminated", 84'(dut.r_s1), 84'(0));
        check("enc2_terminated", 84'(dut.r_s2), 84'(0));
        wait_frames(2);

        // Stall three cycles on word 1.
        bus.ready_i = 1'b0;
        acc0 = words_accepted;
        g = golden(24'hC3A917);
        send(24'hC3A917, t);
        wait_valid(n);
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold_data", 84'(bus.data_o), 84'(g[41:21]));
            check("stall_hold_valid", 84'(bus.valid_o), 84'(1));
        end
        bus.ready_i = 1'b1;
        wait_frames(3);
        check("stall_words_accepted", 84'(words_accepted - acc0), 84'(4));

        // Back-to-back frames with ready held high.
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            send(vecs[i], t);
            if (i > 0) check("frame_spacing", 84'(t - t_prev), 84'(32));
            t_prev = t;
        end
        wait_frames(7);

        // Start during ENC must be ignored.
        send(24'hFFFFFF, t);
        repeat (5) tick();
        bus.data_i  = 24'hFFFF00;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        wait_frames(8);
        repeat (40) tick();
        check("idle_after_ignored", 84'(bus.busy_o), 84'(0));

        // Abort by reset while word 2 is on the bus.
        send(24'h0F0F33, t);
        n = 0;
        while (widx != 2 && n < 60) begin tick(); n++; end
        check("reached_word2", 84'(widx), 84'(2));
        reset_n_i = 1'b0;
        #2;
        check("abort_busy", 84'(bus.busy_o), 84'(0));
        check("abort_valid", 84'(bus.valid_o), 84'(0));
        check("abort_done", 84'(bus.done_o), 84'(0));
        check("abort_data", 84'(bus.data_o), 84'(0));
        tick();
        tick();
        reset_n_i = 1'b1;
        repeat (40) tick();
        check("no_valid_after_abort", 84'(bus.valid_o), 84'(0));

        // Recovery after abort.
        frames_done = 0;
        send(24'h3C5AF0, t);
        wait_frames(1);
`ifdef TURBO_ENC_FRAME_CNT_EN
        check("frame_cnt_after_abort", 84'(frame_cnt), 84'(fc_model));
        for (int f = 1; f < 672; f++) send(24'($urandom), t);
        wait_frames(672);
        check("frame_cnt_model", 84'(frame_cnt), 84'(fc_model));
        check("frame_cnt_672", 84'(frame_cnt), 84'(160));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
